// File: rtl/id_operand_unit.sv
// Operand-fetch stage between decode and execute: register file, EX/MEM/WB
// bypass, load-use hazard detection and the ID/EX pipeline register.
module id_operand_unit #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int FWD_EN = 1,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [4:0]        wb_address,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   port_a,
  output logic [XLEN-1:0]   port_b,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic              ill_reg,
  output logic [PERF_W-1:0] stall_cnt
);
  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [XLEN-1:0]   rf_q [NREGS];
  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   port_a_q, port_a_d, port_b_q, port_b_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic              ex_rd_we_q, ex_rd_we_d, ex_is_load_q, ex_is_load_d;
  logic              ill_q, ill_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              ex_wr, hazard;

  function automatic logic legal(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  assign ex_wr = ex_valid_q & ex_rd_we_q;

  // Illegal indices and x0 never pick up a bypass value.
  function automatic logic [XLEN-1:0] fetch(input logic [4:0] rs);
    logic [XLEN-1:0] v;
    v = '0;
    if (rs != 5'd0 && legal(rs)) begin
      if (FWD_EN != 0 && ex_wr && ex_rd_q == rs && !ex_is_load_q) v = ex_result;
      else if (FWD_EN != 0 && mem_we && mem_rd == rs) v = mem_data;
      else if (wb_we && wb_address == rs) v = wb_data;
      else v = rf_q[rs[AW-1:0]];
    end
    return v;
  endfunction

  function automatic logic blocks(input logic [4:0] rs);
    logic b;
    b = ex_wr && ex_is_load_q && ex_rd_q != 5'd0 && ex_rd_q == rs;
    if (FWD_EN == 0 && rs != 5'd0 &&
        ((ex_wr && ex_rd_q == rs) || (mem_we && mem_rd == rs)))
      b = 1'b1;
    return b;
  endfunction

  assign hazard   = id_valid && ((id_rs1_use && blocks(id_rs1)) ||
                                 (id_rs2_use && blocks(id_rs2)));
  assign id_ready = !hazard && !ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_address != 5'd0 && legal(wb_address)) begin
      rf_q[wb_address[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    port_a_d     = port_a_q;
    port_b_d     = port_b_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_is_load_d = ex_is_load_q;
    ill_d        = ill_q;
    stall_cnt_d  = stall_cnt_q;
    // Flush wins over a stalled execute stage.
    if (flush || (!ex_stall && hazard)) begin
      ex_valid_d   = 1'b0;
      ex_rd_we_d   = 1'b0;
      ex_is_load_d = 1'b0;
      ill_d        = 1'b0;
    end else if (!ex_stall) begin
      if (id_valid) begin
        ex_valid_d   = 1'b1;
        port_a_d     = fetch(id_rs1);
        port_b_d     = fetch(id_rs2);
        ex_rd_d      = id_rd;
        ex_rd_we_d   = id_rd_we;
        ex_is_load_d = id_is_load;
        ill_d        = (id_rs1_use && !legal(id_rs1)) ||
                       (id_rs2_use && !legal(id_rs2)) ||
                       (id_rd_we && !legal(id_rd));
      end else begin
        ex_valid_d = 1'b0;
      end
    end
    if (hazard && !flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      port_a_q     <= '0;
      port_b_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_we_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ill_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      port_a_q     <= port_a_d;
      port_b_q     <= port_b_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_is_load_q <= ex_is_load_d;
      ill_q        <= ill_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign port_a     = port_a_q;
  assign port_b     = port_b_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd_we   = ex_rd_we_q;
  assign ex_is_load = ex_is_load_q;
  assign ill_reg    = ill_q;
  assign stall_cnt  = stall_cnt_q;
endmodule
